column_sweep_ctrl: RTL and testbench
====================================

COLUMN_SWEEP_CTRL -- requirements
Module: column_sweep_ctrl

Interface
REQ-001 Parameter: NCOLS, default 4; number of byte columns swept per job (1..4).
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  one-cycle job request; sampled only in IDLE.
REQ-005 base_row  in  4  first of 4 source rows in vector register file.
REQ-006 dst_row  in  4  first of 4 destination rows.
REQ-007 busy  out  1  high from job acceptance until DONE exits.
REQ-008 done  out  1  one-cycle pulse at job completion.
REQ-009 err  out  1  one-cycle pulse when start is rejected.
REQ-010 rf_fila  out  4  register-file read row base.
REQ-011 rf_columnar  out  2  register-file read column select.
REQ-012 rf_col_read  out  1  register-file column-read enable.
REQ-013 rf_rdata  in  32  register-file column data (combinational read).
REQ-014 rf_waddr, rf_columnaw  out  4, 2  register-file write row base and column select.
REQ-015 rf_wr_en, rf_col_write  out  1, 1  register-file write strobe and column-write mode.
REQ-016 rf_wdata  out  32  register-file write data.
REQ-017 u_data, u_valid / u_ready  out 32, out 1 / in 1  operand to column unit (e.g. MixColumns).
REQ-018 r_data, r_valid  in 32, in 1  result from column unit.

Function
REQ-019 States SHALL be IDLE, READ, ISSUE, WAIT_RES, WRITE, DONE; column counter col[1:0].
REQ-020 IDLE + start with base_row<=12 and dst_row<=12: latch both rows, col<=0, go READ, busy<=1.
REQ-021 IDLE + start with base_row>12 or dst_row>12: stay IDLE, err pulse next cycle, no RF/unit activity.
REQ-022 READ (1 cycle): rf_col_read=1, rf_fila=latched base, rf_columnar=col; capture rf_rdata into operand register; go ISSUE.
REQ-023 ISSUE: u_valid=1, u_data=operand register, held stable until u_valid&&u_ready; then go WAIT_RES.
REQ-024 WAIT_RES: wait for r_valid; capture r_data; go WRITE; r_valid outside WAIT_RES is ignored.
REQ-025 WRITE (1 cycle): rf_wr_en=1, rf_col_write=1, rf_waddr=latched dst, rf_columnaw=col, rf_wdata=captured result.
REQ-026 WRITE with col==NCOLS-1 goes DONE; otherwise col<=col+1, go READ.
REQ-027 DONE (1 cycle): done=1, busy=0 next cycle, return IDLE.
REQ-028 start while busy SHALL be ignored (no queueing, no err).
REQ-029 base_row==dst_row is legal (in-place); per-column read precedes its write, so result is correct.
REQ-030 rf_wr_en, rf_col_read, u_valid SHALL be 0 in every state not listed for them.
REQ-031 Latency with u_ready=1 and r_valid one cycle after issue: 4 cycles/column; NCOLS=4 job = 17 cycles start-to-done.

Reset
REQ-032 rst_n low SHALL force IDLE, col=0, busy=done=err=0, all rf_* and u_* outputs 0, immediately (asynchronous).
REQ-033 Reset mid-job SHALL abandon the job; no partial write after reset release.

Structure
REQ-034 State enum and ROW_LIMIT=12 SHALL live in shared package simd_pkg.
REQ-035 Single flat module; no sub-modules.

Verification
REQ-036 Preload rows 0..3 = 0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF, identity unit, base=0,dst=4 -> rows 4..7 identical, done at cycle 17.
REQ-037 Same preload, unit XOR 0xFFFFFFFF, base=dst=0 -> rows 0..3 bitwise inverted.
REQ-038 start with base_row=13 -> err pulse, busy stays 0, no rf_wr_en.
REQ-039 u_ready low 5 cycles in column 2 -> u_data stable throughout, job finishes 5 cycles later.
REQ-040 rst_n low during WAIT_RES of column 1 -> outputs 0 same cycle, rows 5..7 unchanged.
REQ-041 NCOLS=2 -> only columns 0,1 written, done after 9 cycles.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared types and limits for the column sweep controller and its users.
// Pure declarations, no logic or state.
package simd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        ISSUE,
        WAIT_RES,
        WRITE,
        DONE
    } sweep_state_e;

    // Highest legal first row: a job touches four consecutive rows.
    localparam logic [3:0] ROW_LIMIT = 4'd12;

    function automatic logic rows_ok(input logic [3:0] base_row, input logic [3:0] dst_row);
        return (base_row <= ROW_LIMIT) && (dst_row <= ROW_LIMIT);
    endfunction

endpackage

// File: rtl/column_sweep_ctrl_if.sv
// Job request, register-file column port and column-unit handshake in one bundle.
// master = controller side, slave = requester / register file / column unit side.
interface column_sweep_ctrl_if;

    logic        start;
    logic [3:0]  base_row;
    logic [3:0]  dst_row;
    logic        busy;
    logic        done;
    logic        err;

    logic [3:0]  rf_fila;
    logic [1:0]  rf_columnar;
    logic        rf_col_read;
    logic [31:0] rf_rdata;
    logic [3:0]  rf_waddr;
    logic [1:0]  rf_columnaw;
    logic        rf_wr_en;
    logic        rf_col_write;
    logic [31:0] rf_wdata;

    logic [31:0] u_data;
    logic        u_valid;
    logic        u_ready;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (
        input  start, base_row, dst_row, rf_rdata, u_ready, r_data, r_valid,
        output busy, done, err,
        output rf_fila, rf_columnar, rf_col_read,
        output rf_waddr, rf_columnaw, rf_wr_en, rf_col_write, rf_wdata,
        output u_data, u_valid
    );

    modport slave (
        output start, base_row, dst_row, rf_rdata, u_ready, r_data, r_valid,
        input  busy, done, err,
        input  rf_fila, rf_columnar, rf_col_read,
        input  rf_waddr, rf_columnaw, rf_wr_en, rf_col_write, rf_wdata,
        input  u_data, u_valid
    );

endinterface

// File: rtl/column_sweep_ctrl.sv
// Sweeps NCOLS byte columns: RF column read -> column unit -> RF column write; 4 cycles/column, +1 for DONE.
// Operand held on u_data while u_ready is low; waits indefinitely for r_valid; start ignored while busy.
module column_sweep_ctrl
    import simd_pkg::*;
#(
    parameter int unsigned NCOLS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    column_sweep_ctrl_if.master bus
);

    localparam logic [1:0] LAST_COL = 2'(NCOLS - 1);

    sweep_state_e state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [3:0]   base_q, base_d;
    logic [3:0]   dst_q, dst_d;
    logic [31:0]  opnd_q, opnd_d;
    logic [31:0]  res_q, res_d;
    logic         err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            base_q  <= '0;
            dst_q   <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            base_q  <= base_d;
            dst_q   <= dst_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        base_d  = base_q;
        dst_d   = dst_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        err_d   = 1'b0;

        // Outputs decode from state only, so an asynchronous reset zeroes them at once.
        bus.busy         = (state_q != IDLE);
        bus.done         = 1'b0;
        bus.err          = err_q;
        bus.rf_fila      = '0;
        bus.rf_columnar  = '0;
        bus.rf_col_read  = 1'b0;
        bus.rf_waddr     = '0;
        bus.rf_columnaw  = '0;
        bus.rf_wr_en     = 1'b0;
        bus.rf_col_write = 1'b0;
        bus.rf_wdata     = '0;
        bus.u_data       = '0;
        bus.u_valid      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (rows_ok(bus.base_row, bus.dst_row)) begin
                        base_d  = bus.base_row;
                        dst_d   = bus.dst_row;
                        col_d   = '0;
                        state_d = READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            READ: begin
                bus.rf_col_read = 1'b1;
                bus.rf_fila     = base_q;
                bus.rf_columnar = col_q;
                opnd_d          = bus.rf_rdata;
                state_d         = ISSUE;
            end
            ISSUE: begin
                bus.u_valid = 1'b1;
                bus.u_data  = opnd_q;
                if (bus.u_ready) begin
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (bus.r_valid) begin
                    res_d   = bus.r_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                bus.rf_wr_en     = 1'b1;
                bus.rf_col_write = 1'b1;
                bus.rf_waddr     = dst_q;
                bus.rf_columnaw  = col_q;
                bus.rf_wdata     = res_q;
                if (col_q == LAST_COL) begin
                    state_d = DONE;
                end else begin
                    col_d   = col_q + 2'd1;
                    state_d = READ;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_column_sweep_ctrl.sv
// Bench: two controllers (NCOLS=4 and NCOLS=2) share one register-file model and one column-unit model.
// Byte c of a row is row[8c+:8]; column c of rows r..r+3 packs row r+i's byte c into bits [8i+:8].
module tb_column_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    column_sweep_ctrl_if ifa ();
    column_sweep_ctrl_if ifb ();

    column_sweep_ctrl #(.NCOLS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(ifa));
    column_sweep_ctrl #(.NCOLS(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(ifb));

    logic        sel;
    logic        start_v;
    logic [3:0]  base_v, dst_v;
    logic        u_ready_v;
    logic        r_spur;
    logic        r_valid_v = 1'b0;
    logic [31:0] r_data_v  = '0;
    logic [31:0] xmask;
    logic        load_req;
    logic [31:0] mem [16];
    int          writes = 0;
    int          issues = 0;
    int          total  = 0;
    int          bad    = 0;

    logic        busy_w, done_w, err_w, uvalid_w, wr_w, cw_w;
    logic [3:0]  fila_w, waddr_w;
    logic [1:0]  col_w, colaw_w;
    logic [31:0] wdata_w, udata_w, rdata_w;
    logic [82:0] outs_a, outs_b;

    assign ifa.start    = start_v && !sel;
    assign ifb.start    = start_v && sel;
    assign ifa.base_row = base_v;
    assign ifb.base_row = base_v;
    assign ifa.dst_row  = dst_v;
    assign ifb.dst_row  = dst_v;
    assign ifa.rf_rdata = rdata_w;
    assign ifb.rf_rdata = rdata_w;
    assign ifa.u_ready  = u_ready_v;
    assign ifb.u_ready  = u_ready_v;
    assign ifa.r_valid  = r_valid_v || r_spur;
    assign ifb.r_valid  = r_valid_v || r_spur;
    assign ifa.r_data   = r_data_v;
    assign ifb.r_data   = r_data_v;

    assign busy_w   = sel ? ifb.busy         : ifa.busy;
    assign done_w   = sel ? ifb.done         : ifa.done;
    assign err_w    = sel ? ifb.err          : ifa.err;
    assign uvalid_w = sel ? ifb.u_valid      : ifa.u_valid;
    assign udata_w  = sel ? ifb.u_data       : ifa.u_data;
    assign wr_w     = sel ? ifb.rf_wr_en     : ifa.rf_wr_en;
    assign cw_w     = sel ? ifb.rf_col_write : ifa.rf_col_write;
    assign fila_w   = sel ? ifb.rf_fila      : ifa.rf_fila;
    assign col_w    = sel ? ifb.rf_columnar  : ifa.rf_columnar;
    assign waddr_w  = sel ? ifb.rf_waddr     : ifa.rf_waddr;
    assign colaw_w  = sel ? ifb.rf_columnaw  : ifa.rf_columnaw;
    assign wdata_w  = sel ? ifb.rf_wdata     : ifa.rf_wdata;

    assign outs_a = {ifa.busy, ifa.done, ifa.err, ifa.rf_fila, ifa.rf_columnar, ifa.rf_col_read,
                     ifa.rf_waddr, ifa.rf_columnaw, ifa.rf_wr_en, ifa.rf_col_write, ifa.rf_wdata,
                     ifa.u_data, ifa.u_valid};
    assign outs_b = {ifb.busy, ifb.done, ifb.err, ifb.rf_fila, ifb.rf_columnar, ifb.rf_col_read,
                     ifb.rf_waddr, ifb.rf_columnaw, ifb.rf_wr_en, ifb.rf_col_write, ifb.rf_wdata,
                     ifb.u_data, ifb.u_valid};

    // Register file: combinational column read, column write on the clock edge.
    always_comb begin
        rdata_w = '0;
        for (int i = 0; i < 4; i++) begin
            rdata_w[8*i +: 8] = mem[fila_w + 4'(i)][8*col_w +: 8];
        end
    end

    always @(posedge clk) begin
        if (load_req) begin
            for (int r = 0; r < 16; r++) mem[r] <= 32'hA5A5A5A5;
            mem[0] <= 32'h00112233;
            mem[1] <= 32'h44556677;
            mem[2] <= 32'h8899AABB;
            mem[3] <= 32'hCCDDEEFF;
        end else if (wr_w) begin
            writes <= writes + 1;
            if (cw_w) begin
                for (int i = 0; i < 4; i++) begin
                    mem[waddr_w + 4'(i)][8*colaw_w +: 8] <= wdata_w[8*i +: 8];
                end
            end
        end
    end

    // Column unit: result (operand ^ xmask) valid the cycle after acceptance.
    always @(posedge clk) begin
        r_valid_v <= 1'b0;
        if (uvalid_w && u_ready_v) begin
            r_valid_v <= 1'b1;
            r_data_v  <= udata_w ^ xmask;
            issues    <= issues + 1;
        end
    end

    typedef struct {
        string       name;
        logic        s;
        logic [3:0]  base;
        logic [3:0]  dst;
        logic [31:0] mask;
        int          stall_col;
        int          stall_len;
        logic        poke;
        int          exp_lat;
        int          exp_wr;
        logic [127:0] rows;   // {row3, row2, row1, row0} of the destination block
    } vec_t;

    vec_t vec [6];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic preload();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic run_job(input vec_t v);
        int lat, w0, i0, stall_left, err_seen, busy_bad, ud_bad;
        logic done_seen;
        logic [31:0] ud_hold;
        preload();
        sel = v.s; xmask = v.mask; base_v = v.base; dst_v = v.dst; u_ready_v = 1'b1;
        w0 = writes; i0 = issues;
        lat = 0; done_seen = 1'b0; err_seen = 0; busy_bad = 0; ud_bad = 0;
        stall_left = v.stall_len; ud_hold = '0;
        start_v = 1'b1;
        while (!done_seen && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            start_v = v.poke && (lat == 6);
            if (start_v) base_v = 4'd15;
            if (err_w) err_seen++;
            if (!busy_w) busy_bad++;
            u_ready_v = 1'b1;
            if (uvalid_w && (issues - i0) == v.stall_col && stall_left > 0) begin
                if (stall_left == v.stall_len) ud_hold = udata_w;
                else if (udata_w !== ud_hold) ud_bad++;
                u_ready_v = 1'b0;
                stall_left--;
            end
            if (done_w) done_seen = 1'b1;
        end
        chk({v.name, "_latency"}, 128'(lat), 128'(v.exp_lat));
        chk({v.name, "_writes"}, 128'(writes - w0), 128'(v.exp_wr));
        chk({v.name, "_no_err"}, 128'(err_seen), 128'd0);
        chk({v.name, "_busy_held"}, 128'(busy_bad), 128'd0);
        if (v.stall_len > 0) begin
            chk({v.name, "_udata_stable"}, 128'(ud_bad), 128'd0);
            chk({v.name, "_udata_col2"}, 128'(ud_hold), 128'h0DD995511);
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_row%0d", v.name, i), 128'(mem[v.dst + 4'(i)]), 128'(v.rows[32*i +: 32]));
        end
        @(posedge clk);
        #1;
        chk({v.name, "_post_idle"}, 128'({busy_w, done_w}), 128'd0);
    endtask

    task automatic reject(input logic s, input logic [3:0] b, input logic [3:0] d);
        int w0;
        sel = s; base_v = b; dst_v = d; w0 = writes;
        start_v = 1'b1;
        @(posedge clk);
        #1;
        start_v = 1'b0;
        chk($sformatf("rej_%0d_%0d_err_pulse", b, d), 128'({err_w, busy_w}), 128'b10);
        @(posedge clk);
        #1;
        chk($sformatf("rej_%0d_%0d_err_end", b, d), 128'({err_w, busy_w}), 128'b00);
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("rej_%0d_%0d_no_write", b, d), 128'(writes - w0), 128'd0);
    endtask

    initial begin
        int w0;
        vec[0] = '{"ident",    1'b0, 4'd0,  4'd4,  32'h0,        -1, 0, 1'b0, 17, 4,
                   {32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233}};
        vec[1] = '{"inv_inpl", 1'b0, 4'd0,  4'd0,  32'hFFFFFFFF, -1, 0, 1'b0, 17, 4,
                   {32'h33221100, 32'h77665544, 32'hBBAA9988, 32'hFFEEDDCC}};
        vec[2] = '{"stall",    1'b0, 4'd0,  4'd4,  32'h0,         2, 5, 1'b0, 22, 4,
                   {32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233}};
        vec[3] = '{"poke_d12", 1'b0, 4'd0,  4'd12, 32'h0,        -1, 0, 1'b1, 17, 4,
                   {32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233}};
        vec[4] = '{"n2_copy",  1'b1, 4'd0,  4'd4,  32'h0,        -1, 0, 1'b0,  9, 2,
                   {32'hA5A5EEFF, 32'hA5A5AABB, 32'hA5A56677, 32'hA5A52233}};
        vec[5] = '{"n2_x12",   1'b1, 4'd12, 4'd12, 32'h0F0F0F0F, -1, 0, 1'b0,  9, 2,
                   {32'hA5A5AAAA, 32'hA5A5AAAA, 32'hA5A5AAAA, 32'hA5A5AAAA}};

        rst_n = 1'b0; sel = 1'b0; start_v = 1'b0; base_v = '0; dst_v = '0;
        u_ready_v = 1'b1; r_spur = 1'b0; xmask = '0; load_req = 1'b0;
        #1;
        chk("reset_outs_n4", 128'(outs_a), 128'd0);
        chk("reset_outs_n2", 128'(outs_b), 128'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_reset", 128'({outs_a, outs_b}), 128'd0);

        for (int k = 0; k < 6; k++) run_job(vec[k]);

        reject(1'b0, 4'd13, 4'd0);
        reject(1'b0, 4'd0,  4'd13);
        reject(1'b1, 4'd15, 4'd15);

        // r_valid outside WAIT_RES must not start anything or write.
        sel = 1'b0; w0 = writes; r_spur = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        r_spur = 1'b0;
        chk("spur_rvalid_idle", 128'({busy_w, 32'(writes - w0)}), 128'd0);

        // Reset during column 1 WAIT_RES: job abandoned, only column 0 landed.
        preload();
        sel = 1'b0; xmask = '0; base_v = 4'd0; dst_v = 4'd4; u_ready_v = 1'b1; w0 = writes;
        start_v = 1'b1;
        @(posedge clk);
        #1;
        start_v = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_busy_col0_written", 128'({busy_w, 32'(writes - w0)}), 128'h1_00000001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outs", 128'(outs_a), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("mid_after_busy", 128'(busy_w), 128'd0);
        chk("mid_after_writes", 128'(writes - w0), 128'd1);
        chk("mid_row4", 128'(mem[4]), 128'hA5A5A533);
        chk("mid_row5", 128'(mem[5]), 128'hA5A5A577);
        chk("mid_row6", 128'(mem[6]), 128'hA5A5A5BB);
        chk("mid_row7", 128'(mem[7]), 128'hA5A5A5FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
